// File: rtl/i281_fetch_unit.sv
// i281 instruction fetch unit: request/ack handshake to instruction memory, a
// single instruction register toward decode, branch redirect and halt.
// Optional macro I281_PC_WRAP_EN: sequential consume at the last address wraps to 0 instead of halting.
module i281_fetch_unit #(
    parameter int                  PC_WIDTH    = 6,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_offset,
    input  logic                   halt_req,
    output logic                   halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [PC_WIDTH-1:0]    pc_r, pc_s;
    logic                   halt_pend_r, halt_pend_s;
    logic                   req_r, req_s;
    logic [PC_WIDTH-1:0]    addr_r, addr_s;
    logic [INSTR_WIDTH-1:0] instr_r, instr_s;
    logic [PC_WIDTH-1:0]    ipc_r, ipc_s;
    logic                   valid_r, valid_s;
    logic                   halted_r, halted_s;

    logic [PC_WIDTH-1:0]    seq_pc_s;
    logic [PC_WIDTH-1:0]    next_pc_s;
    logic                   end_halt_s;

    // Modulo-2^PC_WIDTH add; the offset is already PC_WIDTH wide so sign extension is implicit.
    assign seq_pc_s  = ipc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign next_pc_s = branch_taken ? (seq_pc_s + branch_offset) : seq_pc_s;

`ifdef I281_PC_WRAP_EN
    assign end_halt_s = 1'b0;
`else
    assign end_halt_s = !branch_taken && (ipc_r == {PC_WIDTH{1'b1}});
`endif

    // Next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        halt_pend_s = halt_pend_r;
        req_s       = req_r;
        addr_s      = addr_r;
        instr_s     = instr_r;
        ipc_s       = ipc_r;
        valid_s     = valid_r;
        halted_s    = halted_r;
        case (state_r)
            IDLE: begin
                if (halt_req) begin
                    state_s  = HALT;
                    req_s    = 1'b0;
                    halted_s = 1'b1;
                end else begin
                    state_s = FETCH;
                    req_s   = 1'b1;
                    addr_s  = pc_r;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    req_s       = 1'b0;
                    halt_pend_s = 1'b0;
                    if (halt_req || halt_pend_r) begin
                        state_s  = HALT;
                        halted_s = 1'b1;
                    end else begin
                        state_s = HOLD;
                        instr_s = imem_data;
                        ipc_s   = pc_r;
                        valid_s = 1'b1;
                    end
                end else begin
                    // A halt seen mid-request waits for the outstanding ack.
                    halt_pend_s = halt_pend_r | halt_req;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_s = 1'b0;
                    pc_s    = next_pc_s;
                    if (halt_req || end_halt_s) begin
                        state_s  = HALT;
                        halted_s = 1'b1;
                    end else begin
                        state_s = FETCH;
                        req_s   = 1'b1;
                        addr_s  = next_pc_s;
                    end
                end else if (halt_req) begin
                    state_s  = HALT;
                    valid_s  = 1'b0;
                    halted_s = 1'b1;
                end else begin
                    state_s = HOLD;
                end
            end
            HALT: begin
                req_s    = 1'b0;
                valid_s  = 1'b0;
                halted_s = 1'b1;
            end
            default: begin
                state_s  = IDLE;
                req_s    = 1'b0;
                valid_s  = 1'b0;
                halted_s = 1'b0;
            end
        endcase
    end

    // State, PC and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            halt_pend_r <= 1'b0;
            req_r       <= 1'b0;
            addr_r      <= RESET_PC;
            instr_r     <= {INSTR_WIDTH{1'b0}};
            ipc_r       <= {PC_WIDTH{1'b0}};
            valid_r     <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            halt_pend_r <= halt_pend_s;
            req_r       <= req_s;
            addr_r      <= addr_s;
            instr_r     <= instr_s;
            ipc_r       <= ipc_s;
            valid_r     <= valid_s;
            halted_r    <= halted_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr_out   = instr_r;
    assign instr_pc    = ipc_r;
    assign instr_valid = valid_r;
    assign halted      = halted_r;

endmodule
